// File: rtl/cpu_run_controller_pkg.sv
// rtl/cpu_run_controller_pkg.sv - shared state encoding and defaults for the cpu run controller
package cpu_run_controller_pkg;

   localparam int MEM_DEPTH_DEF      = 32;
   localparam int ADDR_W_DEF         = 5;
   localparam int DATA_W_DEF         = 16;
   localparam int TIMEOUT_CYCLES_DEF = 4096;
   localparam int CORE_RST_CYCLES    = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_CORE_RST = 3'd2,
      ST_RUN      = 3'd3,
      ST_DONE     = 3'd4
   } run_state_t;

   typedef enum logic [1:0] {
      PORT_IDLE   = 2'd0,
      PORT_LOADER = 2'd1,
      PORT_CORE   = 2'd2
   } port_sel_t;

   function automatic logic state_is_busy(input run_state_t s);
      return (s == ST_LOAD) || (s == ST_CORE_RST) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/cpu_run_controller_mem_port_mux.sv
// rtl/cpu_run_controller_mem_port_mux.sv - selects loader, core or idle onto the single memory port
module cpu_run_controller_mem_port_mux
   import cpu_run_controller_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  port_sel_t         sel,
   input  logic              write_allow,
   input  logic [ADDR_W-1:0] loader_addr,
   input  logic [DATA_W-1:0] loader_data,
   input  logic              loader_write,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_data,
   input  logic              core_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write
);

   always_comb begin
      mem_addr       = '0;
      mem_write_data = '0;
      mem_write      = 1'b0;
      case (sel)
         PORT_LOADER: begin
            mem_addr       = loader_addr;
            mem_write_data = loader_data;
            mem_write      = loader_write & write_allow;
         end
         PORT_CORE: begin
            mem_addr       = core_addr;
            mem_write_data = core_data;
            mem_write      = core_write & write_allow;
         end
         default: begin
            mem_write = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - loads a program image, runs cpu_core to halt or timeout, reports status
module cpu_run_controller
   import cpu_run_controller_pkg::*;
#(
   parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              host_start,
   input  logic              host_abort,
   input  logic              host_load_valid,
   output logic              host_load_ready,
   input  logic [DATA_W-1:0] host_load_data,
   input  logic              host_load_last,
   output logic              core_reset,
   output logic              core_execute,
   input  logic              core_halted,
   input  logic [ADDR_W-1:0] core_mem_addr,
   input  logic [DATA_W-1:0] core_mem_write_data,
   input  logic              core_mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [15:0]       cycle_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [15:0]       TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]        RST_LAST     = 2'(CORE_RST_CYCLES - 1);

   run_state_t        state_q, state_d;
   logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
   logic [1:0]        rst_cnt_q, rst_cnt_d;
   logic [15:0]       cycle_q, cycle_d;
   logic              timeout_q, timeout_d;
   port_sel_t         port_sel;
   logic              write_allow;
   logic              load_accept;

   assign load_accept = host_load_valid & host_load_ready;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         load_ptr_q <= '0;
         rst_cnt_q  <= '0;
         cycle_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_ptr_q <= load_ptr_d;
         rst_cnt_q  <= rst_cnt_d;
         cycle_q    <= cycle_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      load_ptr_d      = load_ptr_q;
      rst_cnt_d       = rst_cnt_q;
      cycle_d         = cycle_q;
      timeout_d       = timeout_q;
      host_load_ready = 1'b0;
      core_reset      = 1'b1;
      core_execute    = 1'b0;
      done            = 1'b0;
      port_sel        = PORT_IDLE;
      write_allow     = 1'b0;

      case (state_q)
         ST_LOAD: begin
            host_load_ready = 1'b1;
            port_sel        = PORT_LOADER;
            write_allow     = 1'b1;
         end
         ST_RUN: begin
            core_reset   = 1'b0;
            core_execute = 1'b1;
            port_sel     = PORT_CORE;
            write_allow  = 1'b1;
         end
         ST_DONE: begin
            core_reset = 1'b0;
            done       = 1'b1;
            port_sel   = PORT_CORE;
         end
         default: begin
            core_reset = 1'b1;
         end
      endcase

      // Abort outranks every other transition, including a same-cycle halt or last word.
      if (host_abort && state_q != ST_IDLE) begin
         state_d   = ST_IDLE;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (host_start) begin
                  state_d    = ST_LOAD;
                  load_ptr_d = '0;
                  cycle_d    = '0;
                  timeout_d  = 1'b0;
               end
            end
            ST_LOAD: begin
               if (load_accept) begin
                  if (load_ptr_q != LAST_ADDR) begin
                     load_ptr_d = load_ptr_q + ADDR_W'(1);
                  end
                  if (host_load_last || load_ptr_q == LAST_ADDR) begin
                     state_d   = ST_CORE_RST;
                     rst_cnt_d = '0;
                  end
               end
            end
            ST_CORE_RST: begin
               rst_cnt_d = rst_cnt_q + 2'd1;
               if (rst_cnt_q == RST_LAST) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (core_halted) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b0;
               end else if (cycle_q == TIMEOUT_LAST) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end else if (cycle_q != 16'hFFFF) begin
                  cycle_d = cycle_q + 16'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = state_is_busy(state_q);
   assign timeout     = timeout_q;
   assign cycle_count = cycle_q;

   cpu_run_controller_mem_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_port_mux (
      .sel            (port_sel),
      .write_allow    (write_allow),
      .loader_addr    (load_ptr_q),
      .loader_data    (host_load_data),
      .loader_write   (host_load_valid),
      .core_addr      (core_mem_addr),
      .core_data      (core_mem_write_data),
      .core_write     (core_mem_write),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_write      (mem_write)
   );

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - self-checking bench for cpu_run_controller
module tb_cpu_run_controller;

   localparam int MD = 32;
   localparam int TO = 16;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        host_start, host_abort, host_load_valid, host_load_last;
   logic        host_load_ready;
   logic [15:0] host_load_data;
   logic        core_reset, core_execute, core_halted;
   logic [4:0]  core_mem_addr;
   logic [15:0] core_mem_write_data;
   logic        core_mem_write;
   logic [4:0]  mem_addr;
   logic [15:0] mem_write_data;
   logic        mem_write, busy, done, timeout;
   logic [15:0] cycle_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   cpu_run_controller #(
      .MEM_DEPTH      (MD),
      .ADDR_W         (5),
      .DATA_W         (16),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .host_start          (host_start),
      .host_abort          (host_abort),
      .host_load_valid     (host_load_valid),
      .host_load_ready     (host_load_ready),
      .host_load_data      (host_load_data),
      .host_load_last      (host_load_last),
      .core_reset          (core_reset),
      .core_execute        (core_execute),
      .core_halted         (core_halted),
      .core_mem_addr       (core_mem_addr),
      .core_mem_write_data (core_mem_write_data),
      .core_mem_write      (core_mem_write),
      .mem_addr            (mem_addr),
      .mem_write_data      (mem_write_data),
      .mem_write           (mem_write),
      .busy                (busy),
      .done                (done),
      .timeout             (timeout),
      .cycle_count         (cycle_count)
   );

   typedef struct {
      logic        start, abort, valid, last;
      logic [15:0] data;
      logic        halt, cwr;
      logic        ready, busy, done, creset, exec, mw;
      logic [4:0]  addr;
      logic        to;
   } vec_t;

   vec_t tbl[12];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One start/load/run sequence; expectations come from image length, last flag and halt cycle.
   task automatic do_run(input int n, input bit use_last, input int halt_at, input bit gaps);
      logic [15:0] img[40];
      int idx = 0;
      int acc = 0;
      int guard = 0;
      int exp_acc;
      exp_acc = (n < MD) ? n : MD;
      for (int i = 0; i < 40; i++) img[i] = 16'($urandom);
      host_start = 1'b1;
      tick();
      host_start = 1'b0;
      while (acc < exp_acc && guard < 300) begin
         host_load_valid = (idx < n) && (!gaps || ($urandom_range(0, 2) != 0));
         host_load_data  = img[idx < 40 ? idx : 39];
         host_load_last  = use_last && (idx == n - 1);
         settle();
         if (host_load_ready !== 1'b1) chk("load_ready", {31'd0, host_load_ready}, 32'd1);
         if (host_load_valid && host_load_ready) begin
            chk("load_addr", {27'd0, mem_addr}, acc);
            chk("load_wdata", {16'd0, mem_write_data}, {16'd0, img[idx]});
            chk("load_write", {31'd0, mem_write}, 32'd1);
            idx++;
            acc++;
         end
         tick();
         guard++;
      end
      chk("accepted", acc, exp_acc);
      for (int c = 0; c < 2; c++) begin
         host_load_valid = (idx < n);
         host_load_last  = 1'b0;
         settle();
         chk("rst_phase", {26'd0, host_load_ready, busy, core_reset, core_execute, mem_write, done},
             {26'd0, 6'b011000});
         tick();
      end
      host_load_valid = 1'b0;
      for (int r = 0; r < TO; r++) begin
         core_mem_addr       = 5'($urandom);
         core_mem_write_data = 16'($urandom);
         core_mem_write      = 1'($urandom);
         core_halted         = (r == halt_at);
         settle();
         chk("run_ctl", {29'd0, core_execute, core_reset, busy}, 32'b101);
         chk("run_count", {16'd0, cycle_count}, r);
         chk("run_port", {10'd0, mem_addr, mem_write_data, mem_write},
             {10'd0, core_mem_addr, core_mem_write_data, core_mem_write});
         tick();
         if (r == halt_at) break;
      end
      core_halted    = 1'b0;
      core_mem_write = 1'b1;
      settle();
      chk("done_ctl", {27'd0, done, busy, core_execute, core_reset, mem_write}, 32'b10000);
      chk("done_timeout", {31'd0, timeout}, (halt_at >= TO) ? 32'd1 : 32'd0);
      chk("done_count", {16'd0, cycle_count}, (halt_at < TO) ? halt_at : TO - 1);
      core_mem_write = 1'b0;
   endtask

   initial begin
      int mw_seen;
      reset_n = 1'b0;
      host_start = 0; host_abort = 0; host_load_valid = 0; host_load_last = 0;
      host_load_data = '0; core_halted = 0; core_mem_addr = 5'd9;
      core_mem_write_data = 16'h5a5a; core_mem_write = 0;

      tick(); tick(); settle();
      chk("reset_ctl", {26'd0, core_reset, core_execute, host_load_ready, busy, done, mem_write},
          {26'd0, 6'b100000});
      chk("reset_port", {11'd0, mem_addr, mem_write_data}, 32'd0);
      chk("reset_stat", {15'd0, timeout, cycle_count}, 32'd0);
      reset_n = 1'b1;

      tbl[0]  = '{1,0,0,0,16'h0000,0,0, 0,0,0,1,0,0,5'd0,0};
      tbl[1]  = '{0,0,1,0,16'h0101,0,0, 1,1,0,1,0,1,5'd0,0};
      tbl[2]  = '{0,0,1,0,16'h0202,0,0, 1,1,0,1,0,1,5'd1,0};
      tbl[3]  = '{0,0,1,1,16'h0000,0,0, 1,1,0,1,0,1,5'd2,0};
      tbl[4]  = '{0,0,0,0,16'h0000,0,1, 0,1,0,1,0,0,5'd0,0};
      tbl[5]  = '{0,0,0,0,16'h0000,0,1, 0,1,0,1,0,0,5'd0,0};
      tbl[6]  = '{0,0,0,0,16'h0000,1,1, 0,1,0,0,1,1,5'd9,0};
      tbl[7]  = '{0,0,0,0,16'h0000,0,1, 0,0,1,0,0,0,5'd9,0};
      tbl[8]  = '{1,0,0,0,16'h0000,0,0, 0,0,1,0,0,0,5'd9,0};
      tbl[9]  = '{0,0,1,0,16'h0303,0,0, 1,1,0,1,0,1,5'd0,0};
      tbl[10] = '{0,1,1,0,16'h0404,0,0, 1,1,0,1,0,1,5'd1,0};
      tbl[11] = '{0,0,1,0,16'h0000,0,0, 0,0,0,1,0,0,5'd0,0};
      for (int i = 0; i < 12; i++) begin
         tick();
         host_start = tbl[i].start; host_abort = tbl[i].abort;
         host_load_valid = tbl[i].valid; host_load_last = tbl[i].last;
         host_load_data = tbl[i].data; core_halted = tbl[i].halt; core_mem_write = tbl[i].cwr;
         settle();
         chk($sformatf("vec%0d", i),
             {20'd0, host_load_ready, busy, done, core_reset, core_execute, mem_write, mem_addr, timeout},
             {20'd0, tbl[i].ready, tbl[i].busy, tbl[i].done, tbl[i].creset, tbl[i].exec, tbl[i].mw,
              tbl[i].addr, tbl[i].to});
      end
      tick();
      host_start = 0; host_abort = 0; host_load_valid = 0; core_halted = 0; core_mem_write = 0;
      settle();

      // Abort at cycle_count 5 while the core is writing.
      host_start = 1'b1; tick(); host_start = 1'b0;
      host_load_valid = 1'b1; host_load_last = 1'b1; host_load_data = 16'h0001; tick();
      host_load_valid = 1'b0; host_load_last = 1'b0;
      for (int g = 0; g < 10 && !core_execute; g++) tick();
      for (int g = 0; g < 5; g++) tick();
      chk("abort_count", {16'd0, cycle_count}, 32'd5);
      host_abort = 1'b1; core_mem_write = 1'b1; settle(); tick();
      host_abort = 1'b0; settle();
      chk("abort_state", {27'd0, busy, core_reset, core_execute, mem_write, done}, 32'b01000);
      core_mem_write = 1'b0;

      // Reset mid-LOAD with valid held high, then restart.
      host_start = 1'b1; tick(); host_start = 1'b0;
      host_load_valid = 1'b1; host_load_data = 16'haaaa; tick(); tick();
      reset_n = 1'b0; tick(); settle();
      chk("midload_reset", {26'd0, core_reset, core_execute, host_load_ready, busy, done, mem_write},
          {26'd0, 6'b100000});
      chk("midload_port", {11'd0, mem_addr, mem_write_data}, 32'd0);
      reset_n = 1'b1;
      mw_seen = 0;
      for (int g = 0; g < 3; g++) begin tick(); settle(); mw_seen += int'(mem_write); end
      chk("post_reset_nowrite", mw_seen, 0);
      host_start = 1'b1; tick(); host_start = 1'b0; settle();
      chk("restart_load", {25'd0, host_load_ready, mem_write, mem_addr}, {25'd0, 2'b11, 5'd0});
      host_abort = 1'b1; tick(); host_abort = 1'b0; host_load_valid = 1'b0; settle();

      do_run(40, 1'b0, 99, 1'b0);
      do_run(2, 1'b1, TO - 1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         int n;
         bit ul;
         n  = $urandom_range(1, 40);
         ul = (n < MD) ? 1'b1 : 1'($urandom);
         do_run(n, ul, $urandom_range(0, 20), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences one run of cpu_core from power-up to halt:
  - accepts a program image from the host over a valid/ready stream and writes it into the shared 32x16 memory;
  - holds the core in reset;
  - releases the core with execute and watches for halt or timeout;
  - reports done, timeout and cycle count.
- Owns the single memory port and muxes it between the loader and the core.

Parameters:
- MEM_DEPTH, 32: words in program/data memory; load pointer wraps never, saturates at MEM_DEPTH-1.
- ADDR_W, 5: memory address width (log2 MEM_DEPTH).
- DATA_W, 16: memory/instruction word width.
- TIMEOUT_CYCLES, 4096: RUN cycles allowed before forced stop; must be ≤ 65535.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- host_start  in  1  one-cycle pulse; starts a load+run sequence from IDLE or DONE.
- host_abort  in  1  returns to IDLE from any state.
- host_load_valid  in  1  host_load_data is valid.
- host_load_ready  out  1  controller accepts a load word this cycle.
- host_load_data  in  DATA_W  program word.
- host_load_last  in  1  marks the final word of the image.
- core_reset  out  1  active-high reset to cpu_core.
- core_execute  out  1  execute enable to cpu_core.
- core_halted  in  1  halted flag from cpu_core.
- core_mem_addr  in  ADDR_W  core memory address.
- core_mem_write_data  in  DATA_W  core write data.
- core_mem_write  in  1  core write strobe.
- mem_addr  out  ADDR_W  to memory.
- mem_write_data  out  DATA_W  to memory.
- mem_write  out  1  to memory.
- busy  out  1  high in LOAD, CORE_RST, RUN.
- done  out  1  high in DONE.
- timeout  out  1  sticky; set when the run ended by timeout, valid while done.
- cycle_count  out  16  RUN cycles elapsed in the current/last run.

Behaviour:
- Reset (reset_n=0 at an edge), regardless of state:
  - state=IDLE, load_ptr=0, rst_cnt=0, cycle_count=0, timeout=0.
  - Outputs: core_reset=1, core_execute=0, host_load_ready=0, busy=0, done=0, mem_write=0, mem_addr=0, mem_write_data=0.
- States: IDLE, LOAD, CORE_RST, RUN, DONE. Registered FSM; outputs decoded from state.
- IDLE:
  - core_reset=1.
  - host_start → LOAD; clears load_ptr, cycle_count and timeout.
- LOAD:
  - host_load_ready=1, core_reset=1.
  - Memory port is combinational from loader: mem_addr=load_ptr, mem_write_data=host_load_data, mem_write=host_load_valid.
  - On valid&ready: load_ptr+1.
  - If host_load_last=1 or load_ptr==MEM_DEPTH-1 on that accepted word → CORE_RST, rst_cnt=0.
  - Words beyond MEM_DEPTH are never accepted, because ready drops on leaving LOAD.
- CORE_RST:
  - core_reset=1, memory port idle (mem_write=0).
  - rst_cnt increments each cycle; after exactly 2 cycles → RUN.
- RUN:
  - core_reset=0, core_execute=1; memory port muxed from core_mem_* inputs (combinational).
  - cycle_count increments by 1 every RUN cycle.
  - core_halted=1 → DONE, timeout=0.
  - Otherwise, cycle_count==TIMEOUT_CYCLES-1 → DONE, timeout=1.
  - halted and timeout in the same cycle: halted wins, timeout=0.
  - cycle_count never wraps.
- DONE:
  - core_execute=0, core_reset=0 (core state preserved for inspection), done=1.
  - Memory port stays muxed to core with mem_write forced 0.
  - host_start → LOAD; clears cycle_count and timeout.
- host_start in LOAD/CORE_RST/RUN: ignored.
- host_abort in any state except IDLE: → IDLE next edge, core_execute=0, core_reset=1, mem_write=0, timeout cleared. Abort has priority over every other transition in that cycle.
- Latency:
  - host_start to first host_load_ready: 1 cycle.
  - last word accepted to core_execute=1: 3 cycles (2 CORE_RST + entry).
  - core_halted to done=1: 1 cycle.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=3'd0, LOAD=3'd1, CORE_RST=3'd2, RUN=3'd3, DONE=3'd4);
  - MEM_DEPTH/ADDR_W/DATA_W defaults;
  - CORE_RST_CYCLES=2.
- One natural sub-module: mem_port_mux (combinational select of loader/core/idle onto the memory port, with write-force-low). Everything else lives in cpu_run_controller.

Test Plan:
- Load 3 words (0x0101, 0x0202, last 0x0000=HALT) after host_start → mem writes at addr 0,1,2; core_reset low and core_execute high exactly 3 cycles after the last accept; done=1 one cycle after core_halted; timeout=0.
- Host streams 40 words without last → exactly 32 accepted (addr 0..31); ready low from the 33rd word; FSM in CORE_RST.
- Core never halts, TIMEOUT_CYCLES=16 → done=1, timeout=1, cycle_count=15, core_execute=0.
- core_halted asserted on the cycle cycle_count==TIMEOUT_CYCLES-1 → done=1, timeout=0.
- host_abort mid-RUN (cycle_count=5) → next cycle IDLE, core_reset=1, core_execute=0, mem_write=0, busy=0.
- reset_n low for 1 cycle mid-LOAD with valid high → all outputs at reset values; no further mem_write; host_start afterwards restarts the load at addr 0.
